reg_bank: RTL and testbench



---
 rtl/reg_bank.sv | 45 ++++
 tb/tb_reg_bank.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: 32-entry register file, r0 hardwired to zero, $sp reset to SP_INIT,
// two registered read ports with write-first bypass.
module reg_bank #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] SP_INIT = 32'd227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);
    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] rd1_q, rd2_q, rd1_d, rd2_d;
    logic              wr_en;

    assign wr_en = RegWrite && (WriteReg != 5'd0);

    always_comb begin
        rd1_d = (ReadReg1 == 5'd0) ? '0 : (wr_en && WriteReg == ReadReg1) ? WriteData : regs_q[ReadReg1];
        rd2_d = (ReadReg2 == 5'd0) ? '0 : (wr_en && WriteReg == ReadReg2) ? WriteData : regs_q[ReadReg2];
    end

    // Entry 0 is only ever touched by reset, so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= (i == 29) ? SP_INIT : '0;
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            if (wr_en)
                regs_q[WriteReg] <= WriteData;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed scenarios plus a randomized run against an array-based
// model of the register bank.
module tb_reg_bank;
    logic        clk = 1'b0;
    logic        reset, RegWrite;
    logic [4:0]  WriteReg, ReadReg1, ReadReg2;
    logic [31:0] WriteData, ReadData1, ReadData2;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];
    logic [31:0] exp1, exp2;

    reg_bank #(.DATA_W(32), .SP_INIT(32'd227)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    always #5 clk = ~clk;

    // Drive one cycle, clock it, and advance the model with the spec's rules.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        reset = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
        ReadReg1 = r1; ReadReg2 = r2;
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (mem[i]) mem[i] = 32'd0;
            mem[29] = 32'd227;
            exp1 = 32'd0;
            exp2 = 32'd0;
        end else begin
            exp1 = (r1 == 0) ? 32'd0 : (we && wr != 0 && wr == r1) ? wd : mem[r1];
            exp2 = (r2 == 0) ? 32'd0 : (we && wr != 0 && wr == r2) ? wd : mem[r2];
            if (we && wr != 0) mem[wr] = wd;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 0, 29, 5);
            checks += 2;
            if (ReadData1 !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h want %h", ReadData1, 32'd0); end
            if (ReadData2 !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h want %h", ReadData2, 32'd0); end
        end
        cyc(0, 0, 0, 0, 29, 5);
        checks += 2;
        if (ReadData1 !== 32'd227) begin errors++; $display("FAIL reset_sp got %h want %h", ReadData1, 32'd227); end
        if (ReadData2 !== 32'd0) begin errors++; $display("FAIL reset_r5 got %h want %h", ReadData2, 32'd0); end
    endtask

    task automatic test_basic;
        cyc(0, 1, 8, 32'hDEADBEEF, 0, 0);
        cyc(0, 0, 0, 0, 8, 0);
        checks += 2;
        if (ReadData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd1 got %h want %h", ReadData1, 32'hDEADBEEF); end
        if (ReadData2 !== 32'd0) begin errors++; $display("FAIL basic_rd2 got %h want %h", ReadData2, 32'd0); end
    endtask

    task automatic test_zero;
        cyc(0, 1, 0, 32'h12345678, 0, 0);
        checks += 2;
        if (ReadData1 !== 32'd0) begin errors++; $display("FAIL zero_byp1 got %h want %h", ReadData1, 32'd0); end
        if (ReadData2 !== 32'd0) begin errors++; $display("FAIL zero_byp2 got %h want %h", ReadData2, 32'd0); end
        cyc(0, 0, 0, 0, 0, 0);
        checks += 1;
        if (ReadData1 !== 32'd0) begin errors++; $display("FAIL zero_later got %h want %h", ReadData1, 32'd0); end
    endtask

    task automatic test_bypass;
        cyc(0, 1, 31, 32'h1111, 0, 0);
        cyc(0, 1, 31, 32'h2222, 31, 31);
        checks += 2;
        if (ReadData1 !== 32'h2222) begin errors++; $display("FAIL bypass_rd1 got %h want %h", ReadData1, 32'h2222); end
        if (ReadData2 !== 32'h2222) begin errors++; $display("FAIL bypass_rd2 got %h want %h", ReadData2, 32'h2222); end
        cyc(0, 0, 0, 0, 31, 8);
        checks += 2;
        if (ReadData1 !== 32'h2222) begin errors++; $display("FAIL bypass_stored got %h want %h", ReadData1, 32'h2222); end
        if (ReadData2 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_r8 got %h want %h", ReadData2, 32'hDEADBEEF); end
    endtask

    task automatic test_regwrite_low;
        cyc(0, 0, 10, 32'hFFFF, 10, 10);
        checks += 1;
        if (ReadData1 !== 32'd0) begin errors++; $display("FAIL wrlow_same got %h want %h", ReadData1, 32'd0); end
        cyc(0, 0, 0, 0, 10, 0);
        checks += 1;
        if (ReadData1 !== 32'd0) begin errors++; $display("FAIL wrlow_after got %h want %h", ReadData1, 32'd0); end
    endtask

    task automatic test_back_to_back;
        cyc(0, 1, 12, 32'hA1, 0, 0);
        cyc(0, 1, 12, 32'hB2, 0, 0);
        cyc(0, 0, 0, 0, 12, 12);
        checks += 2;
        if (ReadData1 !== 32'hB2) begin errors++; $display("FAIL b2b_rd1 got %h want %h", ReadData1, 32'hB2); end
        if (ReadData2 !== 32'hB2) begin errors++; $display("FAIL b2b_rd2 got %h want %h", ReadData2, 32'hB2); end
    endtask

    task automatic test_reset_collision;
        cyc(1, 1, 29, 32'hAAAA, 29, 29);
        checks += 2;
        if (ReadData1 !== 32'd0) begin errors++; $display("FAIL coll_rd1 got %h want %h", ReadData1, 32'd0); end
        if (ReadData2 !== 32'd0) begin errors++; $display("FAIL coll_rd2 got %h want %h", ReadData2, 32'd0); end
        cyc(0, 0, 0, 0, 29, 8);
        checks += 2;
        if (ReadData1 !== 32'd227) begin errors++; $display("FAIL coll_sp got %h want %h", ReadData1, 32'd227); end
        if (ReadData2 !== 32'd0) begin errors++; $display("FAIL coll_r8 got %h want %h", ReadData2, 32'd0); end
    endtask

    task automatic test_random;
        logic [4:0] wr, r1, r2;
        for (int n = 0; n < 600; n++) begin
            wr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            r2 = ($urandom_range(0, 7) == 0) ? 5'd29 : 5'($urandom_range(0, 5));
            cyc(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), wr, $urandom, r1, r2);
            checks += 2;
            if (ReadData1 !== exp1) begin errors++; $display("FAIL rand_rd1 n=%0d got %h want %h", n, ReadData1, exp1); end
            if (ReadData2 !== exp2) begin errors++; $display("FAIL rand_rd2 n=%0d got %h want %h", n, ReadData2, exp2); end
        end
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        ReadReg1 = '0; ReadReg2 = '0;
        test_reset;
        test_basic;
        test_zero;
        test_bypass;
        test_regwrite_low;
        test_back_to_back;
        test_reset_collision;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
